sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 29 ++
 rtl/sram_arb_pick.sv | 32 +++
 rtl/sram_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and constants for the dual-port SRAM arbiter:
//               FSM state encoding, one-hot grant values and core write-strobe
//               encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // One-hot owner encoding {b,a}
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;

  // Core write-strobe encodings; zero strobe means read
  localparam logic [3:0] WSTRB_READ  = 4'b0000;
  localparam logic [3:0] WSTRB_BYTE  = 4'b0001;
  localparam logic [3:0] WSTRB_HWORD = 4'b0011;
  localparam logic [3:0] WSTRB_WORD  = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pick
// Description : Combinational winner selection between the core port (A) and
//               the loader port (B). On a tie the port that was not granted
//               last wins; feeding a constant GRANT_A as the last grant gives
//               fixed loader-first priority.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic       a_valid_i,
  input  logic       b_valid_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] winner_o
);

  // Single requester wins outright; a tie goes to the port not served last
  always_comb begin
    winner_o = GRANT_NONE;
    if (a_valid_i && b_valid_i) begin
      winner_o = (last_grant_i == GRANT_A) ? GRANT_B : GRANT_A;
    end else if (a_valid_i) begin
      winner_o = GRANT_A;
    end else if (b_valid_i) begin
      winner_o = GRANT_B;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Arbitrates a core port (byte addressed, strobed) and a
//               loader/debug port (word addressed) onto one single-port SRAM.
//               Each access walks IDLE -> ACCESS -> RESP, one access per
//               three cycles. Core addresses above the SRAM range complete
//               without touching the SRAM and set a sticky error flag.
//               Build option SRAM_ARB_RR_EN: round-robin tie-break instead of
//               fixed loader-first priority.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [3:0]        a_wstrb,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [3:0]        b_be,
  input  logic              b_we,
  output logic [DATA_W-1:0] rdata,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_in,
  output logic [3:0]        sram_byte_en,
  input  logic [DATA_W-1:0] sram_data_out,
  output logic [1:0]        grant,
  output logic              oob_err
);

  state_e            state_q;
  logic [1:0]        grant_q;
  logic              a_ready_q;
  logic              b_ready_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [3:0]        be_q;
  logic              resp_rd_q;
  logic              oob_q;

  logic [1:0]        w_win;
  logic [1:0]        w_last;
  logic              w_a_oob;
  logic              w_unused;

  // Byte offset within a word has no meaning for a word-wide SRAM
  assign w_unused = ^a_addr[1:0];

  // Any set bit above the word index puts the core request outside the SRAM
  assign w_a_oob = (a_addr >> (ADDR_W + 2)) != 32'd0;

`ifdef SRAM_ARB_RR_EN
  logic [1:0] last_q;

  // Remember the most recent owner so a tie goes to the other port
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      last_q <= GRANT_B;
    end else if (state_q == ST_IDLE && w_win != GRANT_NONE) begin
      last_q <= w_win;
    end
  end

  assign w_last = last_q;
`else
  // Pretending A was always served last makes B win every tie
  assign w_last = GRANT_A;
`endif

  sram_arb_pick u_pick (
    .a_valid_i    (a_valid),
    .b_valid_i    (b_valid),
    .last_grant_i (w_last),
    .winner_o     (w_win)
  );

  // Access sequencer: capture in IDLE, drive SRAM in ACCESS, respond in RESP
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      grant_q   <= GRANT_NONE;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      be_q      <= '0;
      resp_rd_q <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_win != GRANT_NONE) begin
            state_q <= ST_ACCESS;
            grant_q <= w_win;
            if (w_win == GRANT_A) begin
              if (w_a_oob) begin
                // Completes normally but never reaches the SRAM
                oob_q <= 1'b1;
              end else begin
                addr_q <= a_addr[ADDR_W+1:2];
                if (a_wstrb != WSTRB_READ) begin
                  wr_en_q <= 1'b1;
                  din_q   <= a_wdata;
                  be_q    <= a_wstrb;
                end else begin
                  rd_en_q <= 1'b1;
                end
              end
            end else begin
              addr_q <= b_addr;
              if (b_we) begin
                wr_en_q <= 1'b1;
                din_q   <= b_wdata;
                be_q    <= b_be;
              end else begin
                rd_en_q <= 1'b1;
              end
            end
          end
        end
        ST_ACCESS: begin
          state_q   <= ST_RESP;
          resp_rd_q <= rd_en_q;
          rd_en_q   <= 1'b0;
          wr_en_q   <= 1'b0;
          addr_q    <= '0;
          din_q     <= '0;
          be_q      <= '0;
          a_ready_q <= grant_q[0];
          b_ready_q <= grant_q[1];
        end
        ST_RESP: begin
          state_q   <= ST_IDLE;
          grant_q   <= GRANT_NONE;
          resp_rd_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // SRAM read data arrives during RESP; writes and out-of-range reads return 0
  assign rdata        = resp_rd_q ? sram_data_out : '0;
  assign a_ready      = a_ready_q;
  assign b_ready      = b_ready_q;
  assign grant        = grant_q;
  assign oob_err      = oob_q;
  assign sram_rd_en   = rd_en_q;
  assign sram_wr_en   = wr_en_q;
  assign sram_addr    = addr_q;
  assign sram_data_in = din_q;
  assign sram_byte_en = be_q;

endmodule
`default_nettype wire
